// File: rtl/cpu_run_controller.sv
// cpu_run_controller
//   Run/halt supervisor for the B32P CPU. Holds the core in reset for a fixed
//   number of cycles, releases it for a bounded cycle budget, and stops the
//   run when the PC stays on one value for HALT_STABLE valid samples
//   (jump-to-self), or when the budget runs out.
//
// Ports
//   clk          system clock, rising edge
//   reset        asynchronous active-high reset
//   start        run request, honoured in IDLE (AUTO_START=0) and DONE
//   pc           CPU program counter
//   pc_valid     pc carries a meaningful sample this cycle
//   cpu_reset    active-high reset to the CPU core
//   running      high while the CPU is released
//   done         high once the run has ended
//   halted       run ended by halt detection
//   timeout      run ended by budget expiry
//   cycle_count  clock edges spent running in the current/last run
//   halt_pc      PC at which the halt was detected, else 0
//
// State table
//   IDLE | after reset, CPU held in reset, waiting to begin
//   HOLD | CPU held in reset for RESET_CYCLES edges, results cleared
//   RUN  | CPU released, counting cycles and watching the PC
//   DONE | CPU parked in reset, results frozen until start

module cpu_run_controller #(
  parameter int RESET_CYCLES = 4,
  parameter int MAX_CYCLES   = 128,
  parameter int HALT_STABLE  = 8,
  parameter int CNT_W        = 32,
  parameter int PC_W         = 32,
  parameter bit AUTO_START   = 1'b1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [PC_W-1:0]  pc,
  input  logic             pc_valid,
  output logic             cpu_reset,
  output logic             running,
  output logic             done,
  output logic             halted,
  output logic             timeout,
  output logic [CNT_W-1:0] cycle_count,
  output logic [PC_W-1:0]  halt_pc
);

  localparam int HOLD_W = (RESET_CYCLES > 1) ? $clog2(RESET_CYCLES) : 1;
  localparam int REP_W  = $clog2(HALT_STABLE);

  localparam logic [HOLD_W-1:0] HOLD_LOAD = HOLD_W'(RESET_CYCLES - 1);
  // rep counts matches after the first sample; the match that would take it
  // to HALT_STABLE-1 is the halting one.
  localparam logic [REP_W-1:0]  REP_LAST  = REP_W'(HALT_STABLE - 2);
  localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(MAX_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HOLD = 2'd1,
    RUN  = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t state, state_nx;

  logic [HOLD_W-1:0] hold_cnt;
  logic [REP_W-1:0]  rep_cnt;
  logic [PC_W-1:0]   last_pc;
  logic              last_valid;

  logic cpu_reset_nx, running_nx, done_nx;
  logic hold_done, pc_match, halt_hit, budget_hit, enter_hold;

  assign hold_done  = (hold_cnt == '0);
  assign pc_match   = last_valid && (pc == last_pc);
  assign halt_hit   = (state == RUN) && pc_valid && pc_match && (rep_cnt == REP_LAST);
  assign budget_hit = (state == RUN) && (cycle_count == CNT_LAST);
  assign enter_hold = (state_nx == HOLD) && (state != HOLD);

  // State register; the state-derived outputs are registered alongside so
  // they move on the same edge as the transition.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      cpu_reset <= 1'b1;
      running   <= 1'b0;
      done      <= 1'b0;
    end else begin
      state     <= state_nx;
      cpu_reset <= cpu_reset_nx;
      running   <= running_nx;
      done      <= done_nx;
    end
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE: if (AUTO_START || start)     state_nx = HOLD;
      HOLD: if (hold_done)               state_nx = RUN;
      RUN:  if (halt_hit || budget_hit)  state_nx = DONE;
      DONE: if (start)                   state_nx = HOLD;
      default:                           state_nx = IDLE;
    endcase
  end

  always_comb begin
    cpu_reset_nx = (state_nx != RUN);
    running_nx   = (state_nx == RUN);
    done_nx      = (state_nx == DONE);
  end

  // Run datapath: hold down-counter, cycle counter, halt detector, results.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hold_cnt    <= '0;
      rep_cnt     <= '0;
      last_pc     <= '0;
      last_valid  <= 1'b0;
      cycle_count <= '0;
      halted      <= 1'b0;
      timeout     <= 1'b0;
      halt_pc     <= '0;
    end else if (enter_hold) begin
      hold_cnt    <= HOLD_LOAD;
      rep_cnt     <= '0;
      last_valid  <= 1'b0;
      cycle_count <= '0;
      halted      <= 1'b0;
      timeout     <= 1'b0;
      halt_pc     <= '0;
    end else if (state == HOLD) begin
      if (!hold_done) hold_cnt <= hold_cnt - HOLD_W'(1);
    end else if (state == RUN) begin
      if (cycle_count != '1) cycle_count <= cycle_count + CNT_W'(1);

      // Invalid cycles leave the detector untouched so bubbles do not break
      // a run of equal samples.
      if (pc_valid) begin
        if (pc_match) begin
          rep_cnt <= rep_cnt + REP_W'(1);
        end else begin
          rep_cnt    <= '0;
          last_pc    <= pc;
          last_valid <= 1'b1;
        end
      end

      // Halt has priority when both end conditions land on one edge.
      if (halt_hit) begin
        halted  <= 1'b1;
        halt_pc <= pc;
      end else if (budget_hit) begin
        timeout <= 1'b1;
      end
    end
  end

endmodule
